// File: rtl/multi_tick_gen_pkg.sv
// Shared constants and types for the multi-channel tick generator.
// Rate constants assume a 100 MHz system clock.
package multi_tick_pkg;

    // Default counter width and reset divide value
    localparam int CNT_W_DEF   = 32;
    localparam int DIV_RST_DEF = 100000000;

    // Common divide values at 100 MHz
    localparam int DIV_1HZ   = 100000000;
    localparam int DIV_2HZ   = 50000000;
    localparam int DIV_400HZ = 250000;

    // Why a configuration write was rejected
    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        BAD_DIV  = 2'd1,
        BAD_CH   = 2'd2
    } cfg_err_e;

    // Channel-select width; a single channel still gets a 1-bit select
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Classify a configuration write against the channel count
    function automatic cfg_err_e classify_write(input int ch, input int num_ch,
                                                input logic div_is_zero);
        if (ch >= num_ch) begin
            return BAD_CH;
        end
        if (div_is_zero) begin
            return BAD_DIV;
        end
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/multi_tick_gen_if.sv
// Control/status bundle of the tick generator: config writes, enables,
// phase sync and the per-channel tick/square outputs.
interface multi_tick_gen_if
    import multi_tick_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEF
);
    localparam int CH_W = ch_w(NUM_CH);

    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [CNT_W-1:0]    cfg_div;
    logic [NUM_CH-1:0]   ch_en;
    logic                sync;
    logic [NUM_CH-1:0]   tick_o;
    logic [NUM_CH-1:0]   sq_o;
    logic                cfg_err;

    // Side that programs the block and consumes its enables
    modport master (
        output cfg_we, cfg_ch, cfg_div, ch_en, sync,
        input  tick_o, sq_o, cfg_err
    );

    // The tick generator itself
    modport slave (
        input  cfg_we, cfg_ch, cfg_div, ch_en, sync,
        output tick_o, sq_o, cfg_err
    );

endinterface

// File: rtl/multi_tick_gen_chan.sv
// One divider channel: free-running counter against an active divide
// value, with a shadow register that is only applied at a wrap (or while
// idle / on sync) so the output period never glitches.
module multi_tick_chan
    import multi_tick_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_RST_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             sq
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] div_act_reg;
    logic [CNT_W-1:0] div_shadow_reg;
    logic             pend_reg;
    logic             tick_reg;
    logic             sq_reg;
    logic             wrap;

    // Greater-or-equal rather than equal: after an idle-time apply of a
    // smaller divide the held count may already be past the new end, and
    // this folds it straight into a wrap instead of running to overflow.
    assign wrap = (cnt_reg >= (div_act_reg - CNT_W'(1)));

    // Counter, divide registers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg        <= '0;
            div_act_reg    <= DIV_RST;
            div_shadow_reg <= DIV_RST;
            pend_reg       <= 1'b0;
            tick_reg       <= 1'b0;
            sq_reg         <= 1'b0;
        end else begin
            if (sync) begin
                // Phase restart dominates everything; pending value lands now
                cnt_reg  <= '0;
                tick_reg <= 1'b0;
                sq_reg   <= 1'b0;
                if (pend_reg) begin
                    div_act_reg <= div_shadow_reg;
                    pend_reg    <= 1'b0;
                end
            end else if (en) begin
                if (wrap) begin
                    cnt_reg  <= '0;
                    tick_reg <= 1'b1;
                    sq_reg   <= ~sq_reg;
                    if (pend_reg) begin
                        div_act_reg <= div_shadow_reg;
                        pend_reg    <= 1'b0;
                    end
                end else begin
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                    tick_reg <= 1'b0;
                end
            end else begin
                // Idle: hold count and square, safe to apply at once
                tick_reg <= 1'b0;
                if (pend_reg) begin
                    div_act_reg <= div_shadow_reg;
                    pend_reg    <= 1'b0;
                end
            end

            // A new write always re-arms pend, so a value written on the
            // same cycle as a wrap waits for the following wrap.
            if (wr) begin
                div_shadow_reg <= wr_div;
                pend_reg       <= 1'b1;
            end
        end
    end

    assign tick = tick_reg;
    assign sq   = sq_reg;

endmodule

// File: rtl/multi_tick_gen.sv
// Multi-channel clock-enable generator: decodes config writes onto the
// addressed channel, flags rejected writes, and fans sync out to all
// channels.
module multi_tick_gen
    import multi_tick_pkg::*;
#(
    parameter int               NUM_CH  = 4,
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_RST_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    multi_tick_gen_if.slave bus
);

    logic [NUM_CH-1:0] wr_vec;
    logic [NUM_CH-1:0] tick_vec;
    logic [NUM_CH-1:0] sq_vec;
    cfg_err_e          err_cause;
    logic              wr_ok;
    logic              cfg_err_reg;

    // Validate the incoming write: channel in range and non-zero divide
    always_comb begin
        err_cause = ERR_NONE;
        if (bus.cfg_we) begin
            err_cause = classify_write(int'(bus.cfg_ch), NUM_CH, (bus.cfg_div == '0));
        end
    end

    assign wr_ok = bus.cfg_we && (err_cause == ERR_NONE);

    // One-cycle error pulse for any rejected write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= (err_cause != ERR_NONE);
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign wr_vec[gi] = wr_ok && (int'(bus.cfg_ch) == gi);

        multi_tick_chan #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .en     (bus.ch_en[gi]),
            .sync   (bus.sync),
            .wr     (wr_vec[gi]),
            .wr_div (bus.cfg_div),
            .tick   (tick_vec[gi]),
            .sq     (sq_vec[gi])
        );
    end

    assign bus.tick_o  = tick_vec;
    assign bus.sq_o    = sq_vec;
    assign bus.cfg_err = cfg_err_reg;

endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed bench for multi_tick_gen with three 16-bit channels reset to
// divide-by-4. Inputs change 1 ns after each rising edge; outputs are
// checked at that same point.
module tb_multi_tick_gen;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    multi_tick_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    multi_tick_gen #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .DIV_RST (16'd4)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  ch;
        logic [15:0] div;
        logic [2:0]  en;
        logic        sy;
        logic [2:0]  tick;
        logic [2:0]  sq;
        logic        err;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] %s = %0h ok", name, act);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic we, input logic [1:0] ch, input logic [15:0] div);
        bus.cfg_we  = we;
        bus.cfg_ch  = ch;
        bus.cfg_div = div;
    endtask

    initial begin
        logic s;
        tests = 0;
        fails = 0;

        // Reset release, divide-by-4 on ch0, with two rejected writes
        //           we    ch     div    en      sy    tick    sq      err
        tbl[0]  = '{1'b0, 2'd0, 16'd0, 3'b001, 1'b0, 3'b000, 3'b000, 1'b0};
        tbl[1]  = '{1'b0, 2'd0, 16'd0, 3'b001, 1'b0, 3'b000, 3'b000, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 16'd0, 3'b001, 1'b0, 3'b000, 3'b000, 1'b0};
        tbl[3]  = '{1'b0, 2'd0, 16'd0, 3'b001, 1'b0, 3'b001, 3'b001, 1'b0};
        tbl[4]  = '{1'b1, 2'd0, 16'd0, 3'b001, 1'b0, 3'b000, 3'b001, 1'b1};
        tbl[5]  = '{1'b0, 2'd0, 16'd0, 3'b001, 1'b0, 3'b000, 3'b001, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 16'd0, 3'b001, 1'b0, 3'b000, 3'b001, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 16'd0, 3'b001, 1'b0, 3'b001, 3'b000, 1'b0};
        tbl[8]  = '{1'b1, 2'd3, 16'd7, 3'b001, 1'b0, 3'b000, 3'b000, 1'b1};
        tbl[9]  = '{1'b0, 2'd0, 16'd0, 3'b001, 1'b0, 3'b000, 3'b000, 1'b0};
        tbl[10] = '{1'b0, 2'd0, 16'd0, 3'b001, 1'b0, 3'b000, 3'b000, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 16'd0, 3'b001, 1'b0, 3'b001, 3'b001, 1'b0};

        rst_n = 1'b0;
        set_wr(1'b0, 2'd0, 16'd0);
        bus.ch_en = 3'b001;
        bus.sync  = 1'b0;
        cyc();
        cyc();
        chk("reset tick_o", 32'(bus.tick_o), 0);
        chk("reset sq_o", 32'(bus.sq_o), 0);
        chk("reset cfg_err", 32'(bus.cfg_err), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            set_wr(tbl[i].we, tbl[i].ch, tbl[i].div);
            bus.ch_en = tbl[i].en;
            bus.sync  = tbl[i].sy;
            cyc();
            chk($sformatf("vec%0d tick_o", i), 32'(bus.tick_o), 32'(tbl[i].tick));
            chk($sformatf("vec%0d sq_o", i), 32'(bus.sq_o), 32'(tbl[i].sq));
            chk($sformatf("vec%0d cfg_err", i), 32'(bus.cfg_err), 32'(tbl[i].err));
        end
        set_wr(1'b0, 2'd0, 16'd0);

        // ch1: program div 5 while idle, then rewrite to 3 mid-count
        bus.ch_en = 3'b000;
        set_wr(1'b1, 2'd1, 16'd5);
        cyc();
        set_wr(1'b0, 2'd0, 16'd0);
        cyc();
        bus.ch_en = 3'b010;
        cyc();
        chk("retime e1 tick1", 32'(bus.tick_o[1]), 0);
        cyc();
        chk("retime e2 tick1", 32'(bus.tick_o[1]), 0);
        set_wr(1'b1, 2'd1, 16'd3);
        s = 1'b0;
        for (int e = 3; e <= 14; e++) begin
            logic t;
            cyc();
            set_wr(1'b0, 2'd0, 16'd0);
            t = (e == 5) || (e == 8) || (e == 11) || (e == 14);
            if (t) s = ~s;
            chk($sformatf("retime e%0d tick1", e), 32'(bus.tick_o[1]), 32'(t));
            chk($sformatf("retime e%0d sq1", e), 32'(bus.sq_o[1]), 32'(s));
        end

        // ch0 (div 4, cnt 0, sq 1): run to cnt 2, pause 10 cycles, resume
        bus.ch_en = 3'b001;
        cyc();
        cyc();
        chk("pause pre tick0", 32'(bus.tick_o[0]), 0);
        bus.ch_en = 3'b000;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk($sformatf("pause c%0d tick0", k), 32'(bus.tick_o[0]), 0);
            chk($sformatf("pause c%0d sq0", k), 32'(bus.sq_o[0]), 1);
        end
        bus.ch_en = 3'b001;
        cyc();
        chk("resume c1 tick0", 32'(bus.tick_o[0]), 0);
        cyc();
        chk("resume c2 tick0", 32'(bus.tick_o[0]), 1);
        chk("resume c2 sq0", 32'(bus.sq_o[0]), 0);

        // ch0 div 3, ch1 div 5 left pending, then sync
        bus.ch_en = 3'b011;
        set_wr(1'b1, 2'd0, 16'd3);
        cyc();
        set_wr(1'b1, 2'd1, 16'd5);
        cyc();
        set_wr(1'b0, 2'd0, 16'd0);
        cyc();
        cyc();
        bus.sync = 1'b1;
        cyc();
        bus.sync = 1'b0;
        chk("sync sq_o", 32'(bus.sq_o), 0);
        chk("sync tick_o", 32'(bus.tick_o), 0);
        for (int k = 1; k <= 30; k++) begin
            logic [2:0] exp_t;
            cyc();
            exp_t = {1'b0, (k % 5 == 0), (k % 3 == 0)};
            chk($sformatf("sync+%0d tick_o", k), 32'(bus.tick_o), 32'(exp_t));
        end

        // ch2 divide-by-1: tick every cycle, square toggles every cycle
        bus.ch_en = 3'b000;
        set_wr(1'b1, 2'd2, 16'd1);
        cyc();
        set_wr(1'b0, 2'd0, 16'd0);
        cyc();
        bus.ch_en = 3'b100;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk($sformatf("div1 c%0d tick_o", k), 32'(bus.tick_o), 32'h4);
            chk($sformatf("div1 c%0d sq2", k), 32'(bus.sq_o[2]), 32'(k % 2));
        end

        // Async reset with a pending ch0 write (div 7) that must be lost
        bus.ch_en = 3'b101;
        set_wr(1'b1, 2'd0, 16'd7);
        cyc();
        set_wr(1'b0, 2'd0, 16'd0);
        chk("pre-reset tick2", 32'(bus.tick_o[2]), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset tick_o", 32'(bus.tick_o), 0);
        chk("async reset sq_o", 32'(bus.sq_o), 0);
        chk("async reset cfg_err", 32'(bus.cfg_err), 0);
        cyc();
        rst_n = 1'b1;
        bus.ch_en = 3'b001;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk($sformatf("post-reset c%0d tick_o", k), 32'(bus.tick_o),
                32'((k % 4 == 0) ? 1 : 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
